// File: rtl/openeye_mult_pkg.sv
// Shared helpers for the signed lane multiplier: shift, range test, clamp.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package openeye_mult_pkg;

  // Legal pipeline depth of multiplier_pipe.
  localparam int PIPE_STAGES_MIN = 1;
  localparam int PIPE_STAGES_MAX = 4;

  // Working width for intermediate lane arithmetic; wide enough for any
  // realistic factor pair so shifts and range tests never overflow.
  localparam int WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  // Arithmetic right shift with floor rounding. Shifting by the full product
  // width or more collapses to the sign: 0 for positive, -1 for negative.
  function automatic wide_t asr_floor(wide_t val, int unsigned sh, int unsigned full_w);
    wide_t res;
    if (sh >= full_w) begin
      res = val[WIDE_W-1] ? '1 : '0;
    end else begin
      res = val >>> sh;
    end
    return res;
  endfunction

  // True when val is representable as a w-bit two's-complement number.
  function automatic logic fits_signed(wide_t val, int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    return (val <= hi) && (val >= lo);
  endfunction

  // Clamp val to the signed range of a w-bit number.
  function automatic wide_t clamp_signed(wide_t val, int unsigned w);
    wide_t hi;
    wide_t lo;
    wide_t res;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (val > hi) begin
      res = hi;
    end else if (val < lo) begin
      res = lo;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/mult_lane.sv
// One multiplier lane: full signed product, floor shift by frac, reduce to PROD_W.
// Latency: combinational; the enclosing pipeline registers the result.
// Backpressure: none, stateless. Build option MULTIPLIER_SAT_EN selects clamp vs wrap.
module mult_lane
  import openeye_mult_pkg::*;
#(
  parameter int FAC1_W = 8,
  parameter int FAC2_W = 8,
  parameter int PROD_W = 20,
  parameter int Q_W    = 4
) (
  input  logic              en,
  input  logic [FAC1_W-1:0] fac1,
  input  logic [FAC2_W-1:0] fac2,
  input  logic [Q_W-1:0]    frac,
  output logic [PROD_W-1:0] prod,
  output logic              sat
);

  localparam int unsigned FULL_W = FAC1_W + FAC2_W;

  logic signed [FULL_W-1:0] full_prod;
  wide_t                    full_ext;
  wide_t                    shifted;
  wide_t                    reduced;
  logic                     sat_raw;

  // Product, binary-point shift and range reduction for this lane.
  always_comb begin
    full_prod = FULL_W'($signed(fac1)) * FULL_W'($signed(fac2));
    full_ext  = wide_t'(full_prod);
    shifted   = asr_floor(full_ext, 32'(frac), FULL_W);
`ifdef MULTIPLIER_SAT_EN
    sat_raw   = !fits_signed(shifted, PROD_W);
    reduced   = clamp_signed(shifted, PROD_W);
`else
    sat_raw   = 1'b0;
    reduced   = shifted;
`endif
    prod      = en ? reduced[PROD_W-1:0] : '0;
    sat       = en & sat_raw;
  end

  // Upper bits are dropped on purpose: either already clamped or wrapped.
  logic unused_hi;
  assign unused_hi = ^reduced[WIDE_W-1:PROD_W];

endmodule

// File: rtl/multiplier_pipe.sv
// Multi-lane signed fixed-point multiplier with a valid/ready output pipeline.
// Latency: PIPE_STAGES cycles from acceptance to valid_o; each stall cycle adds one.
// Backpressure: whole pipeline freezes while the last stage holds an unaccepted beat
// (ready_o = !valid_o || ready_i). Build option MULTIPLIER_SAT_EN: clamp + sat_o, else wrap.
module multiplier_pipe
  import openeye_mult_pkg::*;
#(
  parameter int LANES           = 4,
  parameter int DATA_WIDTH_FAC1 = 8,
  parameter int DATA_WIDTH_FAC2 = 8,
  parameter int DATA_WIDTH_PROD = 20,
  parameter int PIPE_STAGES     = 2,
  parameter int Q_BITWIDTH      = $clog2(DATA_WIDTH_FAC1 + DATA_WIDTH_FAC2)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic [LANES-1:0]                   lane_en_i,
  input  logic [LANES*DATA_WIDTH_FAC1-1:0]   factor_1_i,
  input  logic [LANES*DATA_WIDTH_FAC2-1:0]   factor_2_i,
  input  logic [Q_BITWIDTH-1:0]              fraction_bit_i,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [LANES*DATA_WIDTH_PROD-1:0]   product_o,
  output logic [LANES-1:0]                   sat_o
);

  localparam int LAST = PIPE_STAGES - 1;

  if (PIPE_STAGES < PIPE_STAGES_MIN || PIPE_STAGES > PIPE_STAGES_MAX) begin : g_bad_stages
    $error("multiplier_pipe: PIPE_STAGES outside legal range");
  end

  logic                             advance;
  logic [LANES-1:0]                 lane_act;
  logic [LANES*DATA_WIDTH_PROD-1:0] lane_prod;
  logic [LANES-1:0]                 lane_sat;

  logic [PIPE_STAGES-1:0]           stg_vld;
  logic [LANES*DATA_WIDTH_PROD-1:0] stg_prod [PIPE_STAGES];
  logic [LANES-1:0]                 stg_sat  [PIPE_STAGES];

  // The pipe moves as one unit; bubbles keep their slot while stalled.
  assign advance = !stg_vld[LAST] || ready_i;
  assign ready_o = advance;

  // Bubbles enter stage 0 with zero data so idle output slots stay clean.
  assign lane_act = valid_i ? lane_en_i : '0;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mult_lane #(
      .FAC1_W (DATA_WIDTH_FAC1),
      .FAC2_W (DATA_WIDTH_FAC2),
      .PROD_W (DATA_WIDTH_PROD),
      .Q_W    (Q_BITWIDTH)
    ) u_lane (
      .en   (lane_act[g]),
      .fac1 (factor_1_i[g*DATA_WIDTH_FAC1 +: DATA_WIDTH_FAC1]),
      .fac2 (factor_2_i[g*DATA_WIDTH_FAC2 +: DATA_WIDTH_FAC2]),
      .frac (fraction_bit_i),
      .prod (lane_prod[g*DATA_WIDTH_PROD +: DATA_WIDTH_PROD]),
      .sat  (lane_sat[g])
    );
  end

  // Stage registers: load stage 0 from the lanes, shift the rest, hold on stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stg_vld <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        stg_prod[s] <= '0;
        stg_sat[s]  <= '0;
      end
    end else if (advance) begin
      stg_vld[0]  <= valid_i;
      stg_prod[0] <= lane_prod;
      stg_sat[0]  <= lane_sat;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        stg_vld[s]  <= stg_vld[s-1];
        stg_prod[s] <= stg_prod[s-1];
        stg_sat[s]  <= stg_sat[s-1];
      end
    end
  end

  assign valid_o   = stg_vld[LAST];
  assign product_o = stg_prod[LAST];
  assign sat_o     = stg_sat[LAST];

endmodule

// File: tb/tb_multiplier_pipe.sv
// Self-checking bench for multiplier_pipe (4 lanes, 8x8 factors, 12-bit products, 2 stages).
// Directed cases plus randomized traffic with random backpressure against a scoreboard.
// Reference model works from plain integer arithmetic on the lane values.
module tb_multiplier_pipe;

  localparam int LANES = 4;
  localparam int F1    = 8;
  localparam int F2    = 8;
  localparam int PW    = 12;
  localparam int PS    = 2;
  localparam int QW    = 4;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                valid_i;
  logic                ready_o;
  logic [LANES-1:0]    lane_en_i;
  logic [LANES*F1-1:0] factor_1_i;
  logic [LANES*F2-1:0] factor_2_i;
  logic [QW-1:0]       fraction_bit_i;
  logic                valid_o;
  logic                ready_i;
  logic [LANES*PW-1:0] product_o;
  logic [LANES-1:0]    sat_o;

  multiplier_pipe #(
    .LANES           (LANES),
    .DATA_WIDTH_FAC1 (F1),
    .DATA_WIDTH_FAC2 (F2),
    .DATA_WIDTH_PROD (PW),
    .PIPE_STAGES     (PS),
    .Q_BITWIDTH      (QW)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .lane_en_i      (lane_en_i),
    .factor_1_i     (factor_1_i),
    .factor_2_i     (factor_2_i),
    .fraction_bit_i (fraction_bit_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .product_o      (product_o),
    .sat_o          (sat_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [LANES*PW-1:0] prod;
    logic [LANES-1:0]    sat;
  } exp_t;

  exp_t                sb[$];
  int                  n_checks = 0;
  int                  n_fail   = 0;
  int                  n_out    = 0;
  bit                  bp_random = 1'b0;
  bit                  stall_prev = 1'b0;
  logic [LANES*PW-1:0] prev_prod;
  logic [LANES-1:0]    prev_sat;
  logic [LANES*PW-1:0] last_prod;
  logic [LANES-1:0]    last_sat;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] lane_of(input logic [LANES*PW-1:0] p, input int l);
    return 64'(p[l*PW +: PW]);
  endfunction

  // Reference: exact integer product, floor division by 2^frac, then clamp or modular wrap.
  function automatic exp_t model(input logic [LANES-1:0] en, input logic [LANES*F1-1:0] f1,
                                 input logic [LANES*F2-1:0] f2, input logic [QW-1:0] frac);
    exp_t e;
    int   a, b, p, d, fr, v;
    bit   s;
    fr = int'(frac);
    for (int l = 0; l < LANES; l++) begin
      a = $signed(f1[l*F1 +: F1]);
      b = $signed(f2[l*F2 +: F2]);
      p = a * b;
      if (fr >= F1 + F2) begin
        p = (p < 0) ? -1 : 0;
      end else begin
        d = 1 << fr;
        if (p >= 0) p = p / d;
        else        p = -((-p + d - 1) / d);
      end
      s = 1'b0;
`ifdef MULTIPLIER_SAT_EN
      if (p > 2047) begin
        v = 2047; s = 1'b1;
      end else if (p < -2048) begin
        v = -2048; s = 1'b1;
      end else begin
        v = p;
      end
`else
      v = ((p % 4096) + 4096) % 4096;
      if (v >= 2048) v = v - 4096;
`endif
      if (!en[l]) begin
        v = 0; s = 1'b0;
      end
      e.prod[l*PW +: PW] = v[PW-1:0];
      e.sat[l] = s;
    end
    return e;
  endfunction

  // Monitor: handshake rule, hold-on-stall, in-order scoreboard, input capture.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_ni) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      check_eq("ready_rule", 64'(ready_o), 64'(!valid_o || ready_i));
      if (stall_prev) begin
        check_eq("hold_valid", 64'(valid_o), 64'd1);
        check_eq("hold_prod", 64'(product_o), 64'(prev_prod));
        check_eq("hold_sat", 64'(sat_o), 64'(prev_sat));
      end
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_out", 64'(valid_o), 64'd0);
        end else begin
          e = sb.pop_front();
          check_eq("prod", 64'(product_o), 64'(e.prod));
          check_eq("sat", 64'(sat_o), 64'(e.sat));
          n_out++;
          last_prod = product_o;
          last_sat  = sat_o;
        end
      end
      stall_prev = valid_o && !ready_i;
      prev_prod  = product_o;
      prev_sat   = sat_o;
      if (valid_i && ready_o)
        sb.push_back(model(lane_en_i, factor_1_i, factor_2_i, fraction_bit_i));
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (bp_random) ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [LANES-1:0] en, input logic [LANES*F1-1:0] f1,
                      input logic [LANES*F2-1:0] f2, input logic [QW-1:0] fr);
    bit acc;
    int guard;
    valid_i = 1'b1; lane_en_i = en; factor_1_i = f1; factor_2_i = f2; fraction_bit_i = fr;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 200) begin
      @(negedge clk_i);
      acc = ready_o;
      tick();
      guard++;
    end
    if (!acc) check_eq("send_timeout", 64'(acc), 64'd1);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 300) begin
      tick();
      guard++;
    end
    check_eq("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int sent;
    logic [63:0] exp_lane;

    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1; lane_en_i = '0;
    factor_1_i = '0; factor_2_i = '0; fraction_bit_i = '0;
    repeat (3) @(negedge clk_i);
    check_eq("rst_valid", 64'(valid_o), 64'd0);
    check_eq("rst_prod", 64'(product_o), 64'd0);
    check_eq("rst_sat", 64'(sat_o), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    #1;
    check_eq("rst_ready", 64'(ready_o), 64'd1);
    tick();

    // Integer case and two-cycle latency.
    send(4'b0001, 32'h0000_0003, 32'h0000_00FC, 4'd0);
    @(negedge clk_i);
    check_eq("lat_1cyc_valid", 64'(valid_o), 64'd0);
    tick();
    @(negedge clk_i);
    check_eq("lat_2cyc_valid", 64'(valid_o), 64'd1);
    check_eq("int_prod", lane_of(product_o, 0), 64'h0FF4);
    tick();
    drain();

    // Fixed-point cases.
    send(4'b0001, 32'h0000_0040, 32'h0000_0040, 4'd4);
    drain();
    check_eq("fx_64x64_q4", lane_of(last_prod, 0), 64'h100);
    send(4'b0001, 32'h0000_00FF, 32'h0000_0001, 4'd1);
    drain();
    check_eq("fx_m1x1_q1", lane_of(last_prod, 0), 64'hFFF);

    // Range handling.
    send(4'b0001, 32'h0000_007F, 32'h0000_007F, 4'd0);
    drain();
`ifdef MULTIPLIER_SAT_EN
    check_eq("range_prod", lane_of(last_prod, 0), 64'h7FF);
    check_eq("range_sat", 64'(last_sat[0]), 64'd1);
`else
    check_eq("range_prod", lane_of(last_prod, 0), 64'hF01);
    check_eq("range_sat", 64'(last_sat[0]), 64'd0);
`endif

    // Lane enable.
    send(4'b0101, 32'h0505_0505, 32'h0505_0505, 4'd0);
    drain();
    for (int l = 0; l < LANES; l++) begin
      exp_lane = (l % 2 == 0) ? 64'd25 : 64'd0;
      check_eq($sformatf("lane_en_%0d", l), lane_of(last_prod, l), exp_lane);
    end
    check_eq("lane_en_sat", 64'(last_sat), 64'd0);

    // Backpressure: six beats, ready_i low for three cycles.
    n0 = n_out;
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      ready_i = !(c >= 3 && c < 6);
      if (sent < 6) begin
        valid_i = 1'b1; lane_en_i = '1;
        factor_1_i = $urandom; factor_2_i = $urandom;
        fraction_bit_i = 4'($urandom_range(0, 15));
      end else begin
        valid_i = 1'b0;
      end
      @(negedge clk_i);
      if (c >= 3 && c < 6) check_eq("bp_ready_low", 64'(ready_o), 64'd0);
      if (valid_i && ready_o) sent++;
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    drain();
    check_eq("bp_delivered", 64'(n_out - n0), 64'd6);

    // Randomized traffic with random backpressure.
    bp_random = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) == 0) tick();
      else send(4'($urandom), $urandom, $urandom, 4'($urandom_range(0, 15)));
    end
    drain();
    bp_random = 1'b0;
    ready_i = 1'b1;
    tick();

    // Reset with two beats in flight.
    valid_i = 1'b1; lane_en_i = '1; factor_1_i = 32'h1122_3344; factor_2_i = 32'h0203_0405;
    fraction_bit_i = 4'd0;
    @(posedge clk_i); #1;
    factor_1_i = 32'h0506_0708;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    #1;
    rst_ni = 1'b0;
    #1;
    check_eq("midrst_valid", 64'(valid_o), 64'd0);
    check_eq("midrst_prod", 64'(product_o), 64'd0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    #1;
    check_eq("midrst_ready", 64'(ready_o), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      check_eq("post_rst_valid", 64'(valid_o), 64'd0);
      @(posedge clk_i); #1;
    end

    check_eq("sb_final_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
